// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and constants for the RAM arbiter
package ram_arb_pkg;

    localparam int NumReq = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Identifies which requester a read in flight belongs to
    typedef struct packed {
        logic valid;
        logic id;
    } owner_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant logic with priority pointer
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [NumReq-1:0] i_req,
    output logic [NumReq-1:0] o_gnt
);

    logic              r_ptr;
    logic [NumReq-1:0] w_gnt;

    // A lone requester wins outright; under contention the pointer picks
    always_comb begin
        w_gnt = '0;
        if (i_en) begin
            case (i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_ptr ? 2'b10 : 2'b01;
                default: w_gnt = '0;
            endcase
        end
    end

    assign o_gnt = w_gnt;

    // Priority passes to the requester that was not granted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= 1'b0;
        end else if (w_gnt[0]) begin
            r_ptr <= 1'b1;
        end else if (w_gnt[1]) begin
            r_ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - clear sweep, two-requester arbitration and read routing for one RAM port
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AddrWidth    = 10,
    parameter int DataWidth    = 8,
    parameter int RdLatency    = 1,
    parameter int ClearOnReset = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumReq-1:0]           req_i,
    input  logic [NumReq-1:0]           we_i,
    input  logic [NumReq*AddrWidth-1:0] addr_i,
    input  logic [NumReq*DataWidth-1:0] wdata_i,
    output logic [NumReq-1:0]           gnt_o,
    output logic [NumReq-1:0]           rvalid_o,
    output logic [DataWidth-1:0]        rdata_o,
    output logic                        init_done_o,
    output logic                        ram_en_o,
    output logic                        ram_we_o,
    output logic [AddrWidth-1:0]        ram_addr_o,
    output logic [DataWidth-1:0]        ram_wdata_o,
    input  logic [DataWidth-1:0]        ram_rdata_i
);

    localparam state_e ResetState = (ClearOnReset != 0) ? ST_INIT : ST_RUN;
    localparam int     TagDepth   = RdLatency + 1;

    state_e                r_state;
    state_e                w_state_next;
    logic [AddrWidth-1:0]  r_cnt;
    logic                  r_init_done;
    logic                  r_ram_en;
    logic                  r_ram_we;
    logic [AddrWidth-1:0]  r_ram_addr;
    logic [DataWidth-1:0]  r_ram_wdata;
    owner_tag_t            r_tag [TagDepth];

    logic [NumReq-1:0]     w_gnt;
    logic                  w_run;
    logic                  w_any;
    logic                  w_sel;
    logic                  w_sel_we;
    logic [AddrWidth-1:0]  w_sel_addr;
    logic [DataWidth-1:0]  w_sel_wdata;
    logic                  w_cmd_en;
    logic                  w_cmd_we;
    logic [AddrWidth-1:0]  w_cmd_addr;
    logic [DataWidth-1:0]  w_cmd_wdata;
    owner_tag_t            w_last;

    // Grants are held off during reset as well as during the sweep
    assign w_run = (r_state == ST_RUN) && rst_i;

    rr_arb2 u_rr_arb2 (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_en    (w_run),
        .i_req   (req_i),
        .o_gnt   (w_gnt)
    );

    assign gnt_o       = w_gnt;
    assign w_any       = |w_gnt;
    assign w_sel       = w_gnt[1];
    assign w_sel_we    = w_sel ? we_i[1] : we_i[0];
    assign w_sel_addr  = w_sel ? addr_i[2*AddrWidth-1:AddrWidth] : addr_i[AddrWidth-1:0];
    assign w_sel_wdata = w_sel ? wdata_i[2*DataWidth-1:DataWidth] : wdata_i[DataWidth-1:0];

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ResetState;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Leave the sweep once the last address has been issued
    always_comb begin
        w_state_next = r_state;
        if ((r_state == ST_INIT) && (r_cnt == {AddrWidth{1'b1}})) begin
            w_state_next = ST_RUN;
        end
    end

    // Next RAM command: sweep write in ST_INIT, granted access in ST_RUN
    always_comb begin
        w_cmd_en    = 1'b0;
        w_cmd_we    = 1'b0;
        w_cmd_addr  = r_ram_addr;
        w_cmd_wdata = r_ram_wdata;
        case (r_state)
            ST_INIT: begin
                w_cmd_en    = 1'b1;
                w_cmd_we    = 1'b1;
                w_cmd_addr  = r_cnt;
                w_cmd_wdata = '0;
            end
            ST_RUN: begin
                if (w_any) begin
                    w_cmd_en    = 1'b1;
                    w_cmd_we    = w_sel_we;
                    w_cmd_addr  = w_sel_addr;
                    w_cmd_wdata = w_sel_wdata;
                end
            end
            default: ;
        endcase
    end

    // Sweep address counter and sticky init-done flag
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else begin
            if (r_state == ST_INIT) begin
                r_cnt <= r_cnt + {{(AddrWidth-1){1'b0}}, 1'b1};
            end
            r_init_done <= (r_state == ST_RUN);
        end
    end

    // Command register toward the RAM; address and data hold when idle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_ram_en <= w_cmd_en;
            r_ram_we <= w_cmd_we;
            if (w_cmd_en) begin
                r_ram_addr  <= w_cmd_addr;
                r_ram_wdata <= w_cmd_wdata;
            end
        end
    end

    // Owner tags travel alongside the read until the RAM returns its data
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < TagDepth; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= '{valid: w_any && !w_sel_we, id: w_sel};
            for (int i = 1; i < TagDepth; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_last      = r_tag[TagDepth-1];
    assign rvalid_o    = {w_last.valid && w_last.id, w_last.valid && !w_last.id};
    assign rdata_o     = w_last.valid ? ram_rdata_i : '0;
    assign init_done_o = r_init_done;
    assign ram_en_o    = r_ram_en;
    assign ram_we_o    = r_ram_we;
    assign ram_addr_o  = r_ram_addr;
    assign ram_wdata_o = r_ram_wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter at read latencies 1 and 3
module tb_ram_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      req, we;
    logic [2*AW-1:0] addr;
    logic [2*DW-1:0] wdata;

    logic [1:0]    gnt_a, rvalid_a, gnt_b, rvalid_b;
    logic [DW-1:0] rdata_a, rdata_b, ram_wdata_a, ram_wdata_b;
    logic [DW-1:0] ram_rdata_a = '0, ram_rdata_b = '0;
    logic          init_a, init_b, ram_en_a, ram_we_a, ram_en_b, ram_we_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.AddrWidth(AW), .DataWidth(DW), .RdLatency(1), .ClearOnReset(1)) u_dut_a (
        .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a), .init_done_o(init_a),
        .ram_en_o(ram_en_a), .ram_we_o(ram_we_a), .ram_addr_o(ram_addr_a),
        .ram_wdata_o(ram_wdata_a), .ram_rdata_i(ram_rdata_a)
    );

    ram_arbiter #(.AddrWidth(AW), .DataWidth(DW), .RdLatency(3), .ClearOnReset(1)) u_dut_b (
        .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .init_done_o(init_b),
        .ram_en_o(ram_en_b), .ram_we_o(ram_we_b), .ram_addr_o(ram_addr_b),
        .ram_wdata_o(ram_wdata_b), .ram_rdata_i(ram_rdata_b)
    );

    // Behavioural RAM macros: latency 1 for instance A, latency 3 for instance B
    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] mem_b [16];
    logic [DW-1:0] pipe_b [2];
    always @(posedge clk) begin
        if (ram_en_a && ram_we_a) mem_a[ram_addr_a] <= ram_wdata_a;
        if (ram_en_a && !ram_we_a) ram_rdata_a <= mem_a[ram_addr_a];
        if (ram_en_b && ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
        if (ram_en_b && !ram_we_b) pipe_b[0] <= mem_b[ram_addr_b];
        pipe_b[1]   <= pipe_b[0];
        ram_rdata_b <= pipe_b[1];
    end

    // Reference model state
    logic [DW-1:0] shadow [16];
    int            ptr;

    function automatic logic [1:0] model_grant(input logic [1:0] r, input int p);
        if (r == 2'b11) return (p != 0) ? 2'b10 : 2'b01;
        return r;
    endfunction

    function automatic logic [1:0] onehot(input bit id);
        return id ? 2'b10 : 2'b01;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; req = 2'b01; we = 2'b00; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (gnt_a !== 2'b00 || gnt_b !== 2'b00) begin
            errors++; $display("FAIL reset_gnt: got %b/%b expected 00", gnt_a, gnt_b);
        end
        checks++;
        if ({rvalid_a, rdata_a, init_a, ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a} !== '0) begin
            errors++; $display("FAIL reset_outputs_a: got rv=%b rd=%h init=%b en=%b we=%b addr=%h wd=%h expected all 0",
                rvalid_a, rdata_a, init_a, ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a);
        end
        checks++;
        if ({rvalid_b, rdata_b, init_b, ram_en_b, ram_we_b, ram_addr_b, ram_wdata_b} !== '0) begin
            errors++; $display("FAIL reset_outputs_b: got rv=%b rd=%h init=%b en=%b expected all 0",
                rvalid_b, rdata_b, init_b, ram_en_b);
        end
    endtask

    // Sweep after release; covers both the initial release and a mid-operation reset
    task automatic test_sweep(input string tag, input bit hold_req0);
        logic [1:0] exp_g;
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 17) req = 2'b00;
            #1;
            if (k <= 16) begin
                checks++;
                if (ram_en_a !== 1'b1 || ram_we_a !== 1'b1 || ram_addr_a !== 4'(k-1) || ram_wdata_a !== 8'h00 ||
                    ram_en_b !== 1'b1 || ram_addr_b !== 4'(k-1)) begin
                    errors++; $display("FAIL %s_sweep_cmd k=%0d: got en=%b we=%b addr=%0d wd=%h expected 1 1 %0d 00",
                        tag, k, ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a, k-1);
                end
            end
            checks++;
            if (init_a !== (k >= 17) || init_b !== (k >= 17)) begin
                errors++; $display("FAIL %s_init_done k=%0d: got %b/%b expected %b", tag, k, init_a, init_b, k >= 17);
            end
            exp_g = (hold_req0 && k == 16) ? 2'b01 : 2'b00;
            checks++;
            if (gnt_a !== exp_g || gnt_b !== exp_g) begin
                errors++; $display("FAIL %s_sweep_gnt k=%0d: got %b/%b expected %b", tag, k, gnt_a, gnt_b, exp_g);
            end
            checks++;
            if (rvalid_a !== ((hold_req0 && k == 18) ? 2'b01 : 2'b00) ||
                rvalid_b !== ((hold_req0 && k == 20) ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL %s_sweep_rvalid k=%0d: got %b/%b", tag, k, rvalid_a, rvalid_b);
            end
            if (hold_req0 && k == 18) begin
                checks++;
                if (rdata_a !== 8'h00) begin
                    errors++; $display("FAIL %s_swept_read: got %h expected 00", tag, rdata_a);
                end
            end
        end
    endtask

    task automatic test_write_read;
        @(posedge clk); #1;
        req = 2'b01; we = 2'b01; addr = {4'd0, 4'd3}; wdata = {8'h00, 8'hA5};
        #1;
        checks++;
        if (gnt_a !== 2'b01 || gnt_b !== 2'b01) begin
            errors++; $display("FAIL wr_gnt: got %b/%b expected 01", gnt_a, gnt_b);
        end
        @(posedge clk); #1;
        we = 2'b00;
        #1;
        checks++;
        if (gnt_a !== 2'b01) begin
            errors++; $display("FAIL rd_gnt: got %b expected 01", gnt_a);
        end
        checks++;
        if (ram_en_a !== 1'b1 || ram_we_a !== 1'b1 || ram_addr_a !== 4'd3 || ram_wdata_a !== 8'hA5) begin
            errors++; $display("FAIL wr_cmd: got en=%b we=%b addr=%h wd=%h expected 1 1 3 a5",
                ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a);
        end
        for (int t = 1; t <= 5; t++) begin
            @(posedge clk); #1;
            req = 2'b00;
            #1;
            if (t == 1) begin
                checks++;
                if (ram_en_a !== 1'b1 || ram_we_a !== 1'b0 || ram_addr_a !== 4'd3) begin
                    errors++; $display("FAIL rd_cmd: got en=%b we=%b addr=%h expected 1 0 3", ram_en_a, ram_we_a, ram_addr_a);
                end
            end
            checks++;
            if (rvalid_a !== ((t == 2) ? 2'b01 : 2'b00) || rvalid_b !== ((t == 4) ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL wr_rd_rvalid t=%0d: got %b/%b", t, rvalid_a, rvalid_b);
            end
            checks++;
            if (rdata_a !== ((t == 2) ? 8'hA5 : 8'h00) || rdata_b !== ((t == 4) ? 8'hA5 : 8'h00)) begin
                errors++; $display("FAIL wr_rd_rdata t=%0d: got %h/%h", t, rdata_a, rdata_b);
            end
        end
    endtask

    task automatic test_contention;
        logic [1:0] exp_a, exp_b, exp_g;
        logic [7:0] dat_a, dat_b;
        // Lone req1 write of addr 2 hands priority back to req0
        @(posedge clk); #1;
        req = 2'b10; we = 2'b10; addr = {4'd2, 4'd0}; wdata = {8'h3C, 8'h00};
        #1;
        checks++;
        if (gnt_a !== 2'b10) begin
            errors++; $display("FAIL lone_req1_gnt: got %b expected 10", gnt_a);
        end
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            if (i < 8) begin
                req = 2'b11; we = 2'b00; addr = {4'd2, 4'd1};
            end else begin
                req = 2'b00;
            end
            #1;
            exp_g = (i < 8) ? onehot(i % 2 == 1) : 2'b00;
            checks++;
            if (gnt_a !== exp_g || gnt_b !== exp_g) begin
                errors++; $display("FAIL contention_gnt i=%0d: got %b/%b expected %b", i, gnt_a, gnt_b, exp_g);
            end
            exp_a = (i >= 2 && i < 10) ? onehot((i - 2) % 2 == 1) : 2'b00;
            exp_b = (i >= 4 && i < 12) ? onehot((i - 4) % 2 == 1) : 2'b00;
            dat_a = (exp_a == 2'b10) ? 8'h3C : 8'h00;
            dat_b = (exp_b == 2'b10) ? 8'h3C : 8'h00;
            checks++;
            if (rvalid_a !== exp_a || rdata_a !== dat_a) begin
                errors++; $display("FAIL contention_ret_a i=%0d: got %b/%h expected %b/%h", i, rvalid_a, rdata_a, exp_a, dat_a);
            end
            checks++;
            if (rvalid_b !== exp_b || rdata_b !== dat_b) begin
                errors++; $display("FAIL contention_ret_b i=%0d: got %b/%h expected %b/%h", i, rvalid_b, rdata_b, exp_b, dat_b);
            end
        end
    endtask

    task automatic test_unwritten;
        @(posedge clk); #1;
        req = 2'b10; we = 2'b00; addr = {4'd9, 4'd0};
        #1;
        checks++;
        if (gnt_a !== 2'b10) begin
            errors++; $display("FAIL unwritten_gnt: got %b expected 10", gnt_a);
        end
        for (int t = 1; t <= 4; t++) begin
            @(posedge clk); #1;
            req = 2'b00;
            #1;
            checks++;
            if (rvalid_a !== ((t == 2) ? 2'b10 : 2'b00) || rvalid_b !== ((t == 4) ? 2'b10 : 2'b00) ||
                rdata_a !== 8'h00 || rdata_b !== 8'h00) begin
                errors++; $display("FAIL unwritten_read t=%0d: got %b/%h %b/%h expected data 00",
                    t, rvalid_a, rdata_a, rvalid_b, rdata_b);
            end
        end
    endtask

    task automatic test_random;
        bit         p_req [2];
        bit         p_we [2];
        logic [3:0] p_addr [2];
        logic [7:0] p_wdata [2];
        bit         sv_a [8], sv_b [8], sid_a [8], sid_b [8];
        logic [7:0] sd_a [8], sd_b [8];
        logic [1:0] exp_g, exp_rv;
        logic [7:0] exp_rd;
        bit         prev_en, prev_we;
        logic [3:0] prev_addr;
        logic [7:0] prev_wdata;
        int         k, s;
        for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
        shadow[3] = 8'hA5; shadow[2] = 8'h3C;
        ptr = 0;
        for (int i = 0; i < 8; i++) begin sv_a[i] = 0; sv_b[i] = 0; end
        for (int i = 0; i < 2; i++) p_req[i] = 0;
        prev_en = 0; prev_we = 0; prev_addr = '0; prev_wdata = '0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            for (int r = 0; r < 2; r++) begin
                if (!p_req[r]) begin
                    if (c < 390 && $urandom_range(0, 9) < 6) begin
                        p_req[r] = 1; p_we[r] = 1'($urandom_range(0, 1));
                        p_addr[r] = 4'($urandom_range(0, 15)); p_wdata[r] = 8'($urandom_range(0, 255));
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    p_req[r] = 0;
                end
            end
            req = {p_req[1], p_req[0]}; we = {p_we[1], p_we[0]};
            addr = {p_addr[1], p_addr[0]}; wdata = {p_wdata[1], p_wdata[0]};
            #1;
            exp_g = model_grant(req, ptr);
            checks++;
            if (gnt_a !== exp_g || gnt_b !== exp_g) begin
                errors++; $display("FAIL rand_gnt c=%0d: got %b/%b expected %b (req=%b)", c, gnt_a, gnt_b, exp_g, req);
            end
            s = c % 8;
            exp_rv = sv_a[s] ? onehot(sid_a[s]) : 2'b00;
            exp_rd = sv_a[s] ? sd_a[s] : 8'h00;
            checks++;
            if (rvalid_a !== exp_rv || rdata_a !== exp_rd) begin
                errors++; $display("FAIL rand_ret_a c=%0d: got %b/%h expected %b/%h", c, rvalid_a, rdata_a, exp_rv, exp_rd);
            end
            exp_rv = sv_b[s] ? onehot(sid_b[s]) : 2'b00;
            exp_rd = sv_b[s] ? sd_b[s] : 8'h00;
            checks++;
            if (rvalid_b !== exp_rv || rdata_b !== exp_rd) begin
                errors++; $display("FAIL rand_ret_b c=%0d: got %b/%h expected %b/%h", c, rvalid_b, rdata_b, exp_rv, exp_rd);
            end
            sv_a[s] = 0; sv_b[s] = 0;
            checks++;
            if (ram_en_a !== prev_en || ram_we_a !== prev_we ||
                (prev_en && (ram_addr_a !== prev_addr || (prev_we && ram_wdata_a !== prev_wdata)))) begin
                errors++; $display("FAIL rand_cmd c=%0d: got en=%b we=%b addr=%h wd=%h expected %b %b %h %h",
                    c, ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a, prev_en, prev_we, prev_addr, prev_wdata);
            end
            prev_en = (exp_g != 2'b00); prev_we = 0;
            if (exp_g != 2'b00) begin
                k = exp_g[1] ? 1 : 0;
                prev_we = p_we[k]; prev_addr = p_addr[k]; prev_wdata = p_wdata[k];
                if (p_we[k]) begin
                    shadow[p_addr[k]] = p_wdata[k];
                end else begin
                    sv_a[(c + 2) % 8] = 1; sid_a[(c + 2) % 8] = k[0]; sd_a[(c + 2) % 8] = shadow[p_addr[k]];
                    sv_b[(c + 4) % 8] = 1; sid_b[(c + 4) % 8] = k[0]; sd_b[(c + 4) % 8] = shadow[p_addr[k]];
                end
                p_req[k] = 0;
                ptr = 1 - k;
            end
        end
        req = 2'b00;
    endtask

    task automatic test_reset_midop;
        @(posedge clk); #1;
        req = 2'b01; we = 2'b00; addr = {4'd0, 4'd3};
        #1;
        checks++;
        if (gnt_a !== 2'b01 && gnt_a !== 2'b00) begin
            errors++; $display("FAIL midop_gnt: got %b expected 01 or 00", gnt_a);
        end
        @(posedge clk); #1;
        req = 2'b00; rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt_a, rvalid_a, rdata_a, init_a, ram_en_a, ram_we_a, ram_addr_a, ram_wdata_a} !== '0 ||
            {gnt_b, rvalid_b, rdata_b, init_b, ram_en_b, ram_we_b} !== '0) begin
            errors++; $display("FAIL midop_reset_outputs: got rv=%b/%b init=%b en=%b addr=%h expected all 0",
                rvalid_a, rvalid_b, init_a, ram_en_a, ram_addr_a);
        end
        repeat (2) @(posedge clk);
        #1;
        test_sweep("midop", 1'b0);
    endtask

    initial begin
        req = '0; we = '0; addr = '0; wdata = '0;
        test_reset();
        req = 2'b01; we = 2'b00; addr = '0; wdata = '0;
        test_sweep("boot", 1'b1);
        test_write_read();
        test_contention();
        test_unwritten();
        test_random();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for one single-port synchronous RAM (ram_ip).
- After reset it runs a clear sweep that writes zero to every address, then shares the RAM port between two requesters, one access per cycle.
- Read data is routed back to the requester that issued the read.
- Sits between the user-facing logic (e.g. debounced-input handlers) and the RAM macro.

Parameters:
- AddrWidth, 10, RAM address width; depth = 2**AddrWidth.
- DataWidth, 8, RAM word width.
- RdLatency, 1, RAM read latency in cycles from registered command to valid ram_rdata_i (1..3).
- ClearOnReset, 1, 1 = run the zero-fill sweep after reset; 0 = go straight to ST_RUN.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset (asserted when 0).
- req_i  in  2  per-requester access request; held until granted.
- we_i  in  2  per-requester write enable (1 = write, 0 = read).
- addr_i  in  2xAddrWidth  per-requester address.
- wdata_i  in  2xDataWidth  per-requester write data.
- gnt_o  out  2  one-hot grant, combinational, same cycle as accepted req.
- rvalid_o  out  2  read data valid for requester n.
- rdata_o  out  DataWidth  read data (shared bus, qualified by rvalid_o).
- init_done_o  out  1  high once the clear sweep finishes; stays high until reset.
- ram_en_o  out  1  registered RAM enable.
- ram_we_o  out  1  registered RAM write enable.
- ram_addr_o  out  AddrWidth  registered RAM address.
- ram_wdata_o  out  DataWidth  registered RAM write data.
- ram_rdata_i  in  DataWidth  RAM read data.

Behaviour:
- Reset (rst_i = 0, async): state = ST_INIT, or ST_RUN if ClearOnReset = 0.
  - Priority pointer = 0, clear counter = 0, owner pipeline emptied.
  - All outputs 0: gnt_o, rvalid_o, rdata_o, init_done_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o.
  - If ClearOnReset = 0, init_done_o = 1 from the first cycle after reset release.
- ST_INIT:
  - Each cycle issue ram_en_o = 1, ram_we_o = 1, ram_addr_o = counter, ram_wdata_o = 0; counter increments.
  - gnt_o = 0 throughout; requests wait.
  - On the cycle the write to address 2**AddrWidth-1 is issued, go to ST_RUN; init_done_o goes to 1 on the next edge.
  - Sweep takes exactly 2**AddrWidth cycles.
- ST_RUN arbitration (combinational, per cycle):
  - Only req_i[k] set: gnt_o[k] = 1.
  - Both set: grant the requester named by the priority pointer.
  - After any grant, pointer = index of the non-granted requester (strict alternation under contention).
  - No request: pointer unchanged.
- Handshake:
  - A request is consumed on the cycle req_i[k] && gnt_o[k].
  - Requester holds req, we, addr and wdata stable until granted. The requester may drop req before grant without side effect.
- Command timing:
  - Grant in cycle T: ram_* outputs carry that command in cycle T+1.
  - If no grant: ram_en_o = 0 and ram_we_o = 0; address and data hold their last value.
- Read return:
  - Owner tag pipeline of depth 1+RdLatency, tag = {valid, id}, shifted every cycle.
  - For a read granted in T: rvalid_o[id] = 1 and rdata_o = ram_rdata_i in cycle T+1+RdLatency, for exactly one cycle.
  - Writes produce no rvalid.
  - rdata_o = 0 when no rvalid is asserted.
- Back-to-back: one grant per cycle sustained indefinitely; reads pipeline with no bubbles.
- Same-address write then read, in consecutive grants: the read returns the new data (RAM write-first per command order).
- Reset mid-operation: in-flight reads are discarded (no rvalid after release) and the sweep restarts from address 0.
- No backpressure on rvalid_o; requesters must always accept read data.

Decomposition:
- Package ram_arb_pkg:
  - state_e {ST_INIT, ST_RUN}.
  - NumReq = 2.
  - Owner tag struct {logic valid; logic id;}.
- Sub-module rr_arb2: 2-way round-robin grant logic plus priority pointer register, instantiated once.
- Clear sweep, command register and tag pipeline stay in ram_arbiter.

Test Plan (AddrWidth = 4, RdLatency = 1 unless stated):
- Reset release with ClearOnReset = 1:
  - Ram_we_o = 1 for 16 consecutive cycles, addresses 0..15, wdata 0.
  - init_done_o rises the cycle after address 15.
  - A req_i[0] held throughout gets no grant until ST_RUN.
- Req0 writes addr 3 = 0xA5, then req0 reads addr 3:
  - gnt_o[0] on each request cycle.
  - rvalid_o = 2'b01 with rdata_o = 0xA5 exactly 2 cycles after the read grant.
- Both requesters assert reads continuously (req0 addr 1, req1 addr 2):
  - Grants alternate 01, 10, 01, 10 starting with req0.
  - rvalid_o follows the same alternation, offset by 2 cycles.
- Read of an address never written after the sweep (addr 9) -> rdata_o = 0x00.
- RdLatency = 3:
  - Read granted in cycle T -> rvalid_o pulse in T+4 only.
- Reset asserted one cycle after a read grant:
  - No rvalid_o after release.
  - Sweep restarts at address 0.
  - init_done_o = 0 until the sweep completes again.
